// File: rtl/io_out_control_pkg.sv
// Shared types and defaults for the output-side I/O unit.
// The UART state encoding and the pipeline-facing stall signal live here.
package io_out_control_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    typedef struct packed {
        logic out_interrupt;
    } io_sig_t;

endpackage

// File: rtl/io_out_control_if.sv
// OUT-instruction handshake between the execute stage (master) and the I/O unit (slave).
// out_interrupt is the stall request back to the pipeline.
interface io_out_control_if;

    logic       out_valid;
    logic [7:0] out_data;
    logic       out_interrupt;

    modport master (
        output out_valid,
        output out_data,
        input  out_interrupt
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_interrupt
    );

endinterface

// File: rtl/io_out_control_uart_tx.sv
// 8N1 UART serialiser: IDLE -> START -> DATA (LSB first) -> STOP, each bit CLKS_PER_BIT cycles.
// txd is registered from the next-state values so the line changes on the same edge as the state.
module io_out_control_uart_tx
    import io_out_control_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                if (tx_start) begin
                    state_d = UART_START;
                    shift_d = tx_data;
                    bit_d   = '0;
                end
            end
            UART_START: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = UART_DATA;
                    bit_d   = '0;
                end
            end
            UART_DATA: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            UART_STOP: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == UART_IDLE);
        unique case (state_d)
            UART_START: txd_d = 1'b0;
            UART_DATA:  txd_d = shift_d[0];
            default:    txd_d = 1'b1;
        endcase
    end

    assign txd = txd_q;

endmodule

// File: rtl/io_out_control.sv
// Output I/O unit: buffers OUT bytes in a FIFO and serialises them onto a UART line.
// Stalls the pipeline via out_interrupt when an OUT arrives while the FIFO is full.
module io_out_control
    import io_out_control_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        rstn,
    io_out_control_if.slave             out_bus,
    output logic                        txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, empty, push, pop, tx_ready;
    io_sig_t          io_sig;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Full stalls regardless of a same-cycle pop: there is no bypass path.
    assign io_sig.out_interrupt = out_bus.out_valid & full;
    assign out_bus.out_interrupt = io_sig.out_interrupt;

    assign push = out_bus.out_valid & ~full;
    assign pop  = tx_ready & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out_bus.out_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    io_out_control_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rstn    (rstn),
        .tx_start(pop),
        .tx_data (mem_q[rd_ptr_q]),
        .tx_ready(tx_ready),
        .txd     (txd)
    );

    assign tx_busy    = ~tx_ready;
    assign fifo_count = count_q;

endmodule

// File: doc/io_out_control.md
Name: io_out_control

Overview:
- Output-side I/O unit. It accepts bytes produced by OUT instructions in the execute stage and buffers them in a small FIFO.
- It serialises the buffered bytes onto a UART TX line (8N1).
- It raises io_sig.out_interrupt, the stall request consumed by the pipeline stall logic, whenever an OUT would overflow the FIFO. The pipeline holds the OUT instruction and retries it until the byte is accepted.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; must be a power of two and at least 2.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- out_valid  input  1  an OUT instruction is in execute this cycle; held high while stalled.
- out_data  input  8  byte to transmit; valid when out_valid is high.
- out_interrupt  output  1  stall request; drives io_sig.out_interrupt.
- txd  output  1  UART serial line; idle high.
- tx_busy  output  1  serialiser not in IDLE (debug/status).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries (debug/status).

Behaviour:
- Reset, asserted asynchronously:
  - FIFO empty, fifo_count=0.
  - FSM=IDLE, txd=1, tx_busy=0.
  - bit and baud counters cleared.
  - out_interrupt=0, because it is combinational and fifo_count=0.
  - A byte in flight at reset is abandoned; no partial frame resumes afterwards.
- Stall rule: out_interrupt = out_valid & (fifo_count == FIFO_DEPTH).
  - Combinational, with no dependence on this cycle's pop, so no bypass path exists.
  - Being full forces a stall even if a pop occurs in the same cycle.
- Push: when out_valid & ~full, out_data is written at the rising edge and fifo_count increments.
  - Each accepted OUT is pushed exactly once.
  - The pipeline deasserts out_valid or presents the next OUT the following cycle.
- Pop: when FSM=IDLE & ~empty, the head byte is loaded into the shift register, FSM goes to START, and fifo_count decrements.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- FSM IDLE->START->DATA->STOP->IDLE. A baud counter counts 0..CLKS_PER_BIT-1; each state or bit lasts exactly CLKS_PER_BIT cycles.
  - IDLE: txd=1; leaves on a pop.
  - START: txd=0 for one bit time, then DATA with bit index 0.
  - DATA: txd=shift[0], LSB first; shift right at each bit end; after bit index 7 go to STOP.
  - STOP: txd=1 for one bit time, then IDLE.
  - Back-to-back frames: the next pop happens in the first IDLE cycle. The inter-frame gap is therefore one clock beyond the stop bit.
- Latency:
  - An OUT accepted at edge t, with FIFO empty and FSM idle, is popped at edge t+1.
  - txd falls after edge t+1.
  - One frame occupies 10*CLKS_PER_BIT cycles.
- txd is registered, so it is glitch-free.

Decomposition:
- Shared package / common params:
  - UART state enum uart_state_t {UART_IDLE, UART_START, UART_DATA, UART_STOP}.
  - Default baud constant.
  - out_interrupt stays the existing io_sig_t field.
- Sub-module uart_tx: FSM, baud counter and shift register.
  - Interface: clk, rstn, tx_start, tx_data[7:0], tx_ready, txd.
  - tx_ready == (state==UART_IDLE).
- The FIFO stays inline in io_out_control.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated):
1. Single byte: push 8'hA5 into an empty FIFO.
   - txd falls after the edge following the push.
   - Sampled line: 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 4 cycles.
   - tx_busy is high for exactly 40 cycles.
   - out_interrupt stays 0 throughout.
2. Fill and stall: push 5 bytes on consecutive cycles, holding out_valid.
   - Bytes 1 and 2 are accepted, the first pops at once, and bytes 3-5 fill the FIFO to fifo_count=4.
   - Byte 6 presented raises out_interrupt=1 until the first frame ends and the second byte pops (fifo_count 4->3).
   - out_interrupt drops the cycle after that pop.
   - The held byte is then accepted exactly once.
3. Pointer wrap: stream 10 bytes 8'h00..8'h09 with stall-respecting handshakes.
   - Decoded txd frames equal 00..09 in order, with no duplicates or losses.
4. Simultaneous push/pop: FIFO holding 1 byte, push on the same cycle as the pop.
   - fifo_count stays 1.
   - The next frame carries the pushed byte.
5. Reset mid-frame: assert rstn=0 during DATA bit 3.
   - txd=1, tx_busy=0, fifo_count=0 immediately, without waiting for a clock edge.
   - After release, a new push of 8'h3C transmits a clean frame.
6. Full but no OUT: FIFO full with out_valid=0.
   - out_interrupt=0.
   - With FIFO_DEPTH=2, a full FIFO and out_valid=1, out_interrupt=1.
